msrv32_pc_gen: RTL
==================

MSRV32_PC_GEN -- requirements
Module: msrv32_pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC/address width.
REQ-002 SHALL have parameter BOOT_ADDRESS, default 0: PC loaded on reset and on pc_src 00.
REQ-003 SHALL have parameter IALIGN, default 32, legal 32 or 16: instruction alignment in bits.
REQ-004 SHALL have port clk_in, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_in, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port pc_src_in, input, 2: 00 boot, 01 epc, 10 trap, 11 sequential/branch.
REQ-007 SHALL have ports epc_in and trap_address_in, input, XLEN each: return and trap targets.
REQ-008 SHALL have port branch_taken_in, input, 1: a jump/branch is taken this cycle.
REQ-009 SHALL have port iaddr_in, input, XLEN-1: branch target bits [XLEN-1:1]; bit 0 is forced 0.
REQ-010 SHALL have port ahb_ready_in, input, 1: fetch bus accepts an address this cycle.
REQ-011 SHALL have port pc_out, output, XLEN: registered current PC.
REQ-012 SHALL have ports pc_mux_out and iaddr_out, output, XLEN: next-PC selection and issued fetch address.
REQ-013 SHALL have port pc_plus_4_out, output, XLEN: pc_out + 4, modulo 2^XLEN.
REQ-014 SHALL have ports misaligned_instr_logic_out and redirect_pending_out, output, 1 each.

Function
REQ-015 SHALL select the next PC by priority: boot > epc > trap > branch target > pc_out + 4.
REQ-016 SHALL treat a redirect as pc_src_in != 11, or pc_src_in == 11 with branch_taken_in = 1.
REQ-017 SHALL flag a misaligned branch combinationally when branch_taken_in = 1, pc_src_in = 11 and target bit [1] = 1 with IALIGN = 32 (never with IALIGN = 16).
REQ-018 SHALL, on a misaligned branch, neither load the target nor advance; pc_mux_out = pc_out.
REQ-019 SHALL implement states RUN, HOLD and HOLD_PEND.
REQ-020 SHALL, in RUN with ahb_ready_in = 1, load pc_out <= pc_mux_out and drive iaddr_out = pc_mux_out.
REQ-021 SHALL, in RUN with ahb_ready_in = 0, hold pc_out, drive iaddr_out = pc_out, and go to HOLD, or to HOLD_PEND if a redirect is present.
REQ-022 SHALL, while in HOLD_PEND, keep a captured target and its priority level, and assert redirect_pending_out.
REQ-023 SHALL replace the captured target with a new redirect only if the new priority is greater than or equal to the captured priority.
REQ-024 SHALL, on ahb_ready_in = 1 in HOLD_PEND, merge the captured target into the REQ-015 priority with any same-cycle redirect (equal priority: live input wins), load the result, clear pending, and enter RUN.
REQ-025 SHALL, on ahb_ready_in = 1 in HOLD, behave as RUN with ahb_ready_in = 1 and enter RUN.
REQ-026 SHALL wrap pc_out + 4 at 2^XLEN without any flag.

Reset
REQ-027 SHALL, when rst_in = 1 at a clock edge, set pc_out = BOOT_ADDRESS, state = RUN and pending cleared, regardless of the current state.
REQ-028 SHALL, during reset, drive pc_mux_out = iaddr_out = BOOT_ADDRESS, with misaligned_instr_logic_out = 0 and redirect_pending_out = 0.

Structure
REQ-029 SHALL take the pc_src encodings, the state enumeration and the priority-level encoding from the shared package msrv32_pkg.
REQ-030 SHALL place the capture register and priority compare in sub-module msrv32_redirect_buf.

Verification
REQ-031 SHALL check: reset released, ahb_ready_in = 1, pc_src_in = 11 for 3 cycles -> pc_out = 0x0, 0x4, 0x8, 0xC.
REQ-032 SHALL check: pc_out = 0x100, branch_taken_in = 1, iaddr_in gives 0x200, ready = 1 -> next pc_out = 0x200.
REQ-033 SHALL check: ready = 0 and trap 0x80 presented for one cycle, then ready = 1 two cycles later -> redirect_pending_out = 1 while stalled, then pc_out = 0x80.
REQ-034 SHALL check: pending trap 0x80 and a later branch to 0x300 while stalled -> pc_out = 0x80 on release.
REQ-035 SHALL check: IALIGN = 32, branch target 0x102 -> misaligned_instr_logic_out = 1 and pc_out held.
REQ-036 SHALL check: rst_in asserted while in HOLD_PEND -> pc_out = BOOT_ADDRESS and pending cleared on the next edge.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 fetch front end: pc_src select values,
// PC generator states and redirect priority levels.
package msrv32_pkg;

    typedef enum logic [1:0] {
        PC_BOOT = 2'b00,
        PC_EPC  = 2'b01,
        PC_TRAP = 2'b10,
        PC_SEQ  = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_HOLD      = 2'b01,
        ST_HOLD_PEND = 2'b10
    } pc_state_e;

    // Ordered so that a larger value always means a stronger redirect.
    typedef enum logic [2:0] {
        LVL_NONE   = 3'd0,
        LVL_BRANCH = 3'd1,
        LVL_TRAP   = 3'd2,
        LVL_EPC    = 3'd3,
        LVL_BOOT   = 3'd4
    } redir_lvl_e;

endpackage

// File: rtl/msrv32_redirect_buf.sv
// Holds the strongest redirect seen while the fetch bus is stalled; a new
// redirect replaces the held one only at equal or higher priority.
module msrv32_redirect_buf
    import msrv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            clear_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] target_i,
    input  redir_lvl_e      level_i,
    output logic            valid_o,
    output logic [XLEN-1:0] target_o,
    output redir_lvl_e      level_o
);

    redir_lvl_e      level_q, level_d;
    logic [XLEN-1:0] target_q, target_d;

    always_comb begin
        level_d  = level_q;
        target_d = target_q;
        if (clear_i) begin
            level_d  = LVL_NONE;
            target_d = '0;
        end else if (load_i && (level_i != LVL_NONE) && (level_i >= level_q)) begin
            level_d  = level_i;
            target_d = target_i;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            level_q  <= LVL_NONE;
            target_q <= '0;
        end else begin
            level_q  <= level_d;
            target_q <= target_d;
        end
    end

    assign valid_o  = (level_q != LVL_NONE);
    assign target_o = target_q;
    assign level_o  = level_q;

endmodule

// File: rtl/msrv32_pc_gen.sv
// Program counter generator: selects the next PC by redirect priority and
// buffers redirects that arrive while the fetch bus is not ready.
module msrv32_pc_gen
    import msrv32_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] BOOT_ADDRESS = '0,
    parameter int              IALIGN       = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [1:0]      pc_src_in,
    input  logic [XLEN-1:0] epc_in,
    input  logic [XLEN-1:0] trap_address_in,
    input  logic            branch_taken_in,
    input  logic [XLEN-2:0] iaddr_in,
    input  logic            ahb_ready_in,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_mux_out,
    output logic [XLEN-1:0] iaddr_out,
    output logic [XLEN-1:0] pc_plus_4_out,
    output logic            misaligned_instr_logic_out,
    output logic            redirect_pending_out
);

    pc_state_e       state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] br_target, pc_plus_4, live_pc, merged_pc, pend_pc;
    redir_lvl_e      live_lvl, pend_lvl;
    logic            pend_vld, misaligned;

    assign br_target  = {iaddr_in, 1'b0};
    assign pc_plus_4  = pc_q + XLEN'(4);
    assign misaligned = (IALIGN == 32) && branch_taken_in &&
                        (pc_src_in == PC_SEQ) && br_target[1];

    // A misaligned branch is not a redirect: it neither loads nor gets captured.
    always_comb begin
        live_pc  = pc_plus_4;
        live_lvl = LVL_NONE;
        case (pc_src_in)
            PC_BOOT: begin live_pc = BOOT_ADDRESS;    live_lvl = LVL_BOOT; end
            PC_EPC:  begin live_pc = epc_in;          live_lvl = LVL_EPC;  end
            PC_TRAP: begin live_pc = trap_address_in; live_lvl = LVL_TRAP; end
            default: begin
                if (branch_taken_in && misaligned) begin
                    live_pc = pc_q;
                end else if (branch_taken_in) begin
                    live_pc  = br_target;
                    live_lvl = LVL_BRANCH;
                end
            end
        endcase
    end

    // Captured target wins only when strictly stronger than the live request.
    assign merged_pc = (pend_vld && (pend_lvl > live_lvl)) ? pend_pc : live_pc;

    msrv32_redirect_buf #(.XLEN(XLEN)) u_redirect_buf (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear_i  (ahb_ready_in),
        .load_i   (!ahb_ready_in),
        .target_i (live_pc),
        .level_i  (live_lvl),
        .valid_o  (pend_vld),
        .target_o (pend_pc),
        .level_o  (pend_lvl)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_RUN;
            pc_q    <= BOOT_ADDRESS;
        end else begin
            case (state_q)
                ST_RUN, ST_HOLD: begin
                    if (ahb_ready_in) begin
                        pc_q    <= merged_pc;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= (live_lvl != LVL_NONE) ? ST_HOLD_PEND : ST_HOLD;
                    end
                end
                ST_HOLD_PEND: begin
                    if (ahb_ready_in) begin
                        pc_q    <= merged_pc;
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign pc_out                     = pc_q;
    assign pc_plus_4_out              = pc_plus_4;
    assign pc_mux_out                 = rst_in ? BOOT_ADDRESS : merged_pc;
    assign iaddr_out                  = rst_in ? BOOT_ADDRESS :
                                        (ahb_ready_in ? merged_pc : pc_q);
    assign misaligned_instr_logic_out = !rst_in && misaligned;
    assign redirect_pending_out       = !rst_in && pend_vld;

endmodule
